mem_access_master: RTL and testbench

- MEM-stage initiator for the processor's data memory port.
- Converts the pipeline's load/store enables into a registered request/acknowledge transaction toward the data memory.
- Freezes the pipeline until the transaction completes, and returns load data.
- Screens addresses for alignment and range before issuing a request, and times out memories that never acknowledge.

---
 rtl/mem_access_master_if.sv | 22 ++
 rtl/mem_access_master.sv | 102 ++++++++++
 tb/tb_mem_access_master.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_master_if.sv
// Data-memory port bundle between the MEM-stage initiator and the data memory.
// The master issues a held request; the slave answers with m_ack and m_rdata.
interface mem_access_master_if #(
  parameter int MEM_ADDR_W = 18
);
  logic                  m_req;
  logic                  m_we;
  logic [MEM_ADDR_W-1:0] m_addr;
  logic [31:0]           m_wdata;
  logic [31:0]           m_rdata;
  logic                  m_ack;

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  m_rdata, m_ack
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output m_rdata, m_ack
  );
endinterface

// File: rtl/mem_access_master.sv
// MEM-stage initiator: screens load/store accesses, runs a req/ack transaction
// toward data memory with a timeout, and holds the pipeline until it completes.
module mem_access_master #(
  parameter int MEM_ADDR_W = 18,
  parameter int BASE_ADDR  = 1024,
  parameter int DEPTH      = 65280,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] st_val,
  output logic        freeze,
  output logic [31:0] rd_data,
  output logic        err,
  mem_access_master_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // 33-bit bounds so the upper limit never wraps and the compare sees all 32 address bits
  localparam logic [32:0] ADDR_LO = 33'(BASE_ADDR);
  localparam logic [32:0] ADDR_HI = 33'(BASE_ADDR) + 33'(4) * 33'(DEPTH);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             access;
  logic             fault;

  assign access = mem_r_en | mem_w_en;
  assign fault  = (mem_r_en & mem_w_en)
                | (address[1:0] != 2'b00)
                | ({1'b0, address} < ADDR_LO)
                | ({1'b0, address} >= ADDR_HI);

  assign freeze = access & (state_reg != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      rd_data     <= '0;
      err         <= 1'b0;
      bus.m_req   <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (access) begin
            err <= 1'b0;
            if (fault) begin
              err       <= 1'b1;
              rd_data   <= '0;
              state_reg <= DONE;
            end else begin
              bus.m_addr  <= address[MEM_ADDR_W-1:0];
              bus.m_wdata <= st_val;
              bus.m_we    <= mem_w_en;
              bus.m_req   <= 1'b1;
              cnt_reg     <= '0;
              state_reg   <= REQ;
            end
          end
        end
        REQ: begin
          // An ack on the final allowed cycle still completes cleanly
          if (bus.m_ack) begin
            if (!bus.m_we) begin
              rd_data <= bus.m_rdata;
            end
            bus.m_req <= 1'b0;
            state_reg <= DONE;
          end else if (cnt_reg == CNT_LAST) begin
            err       <= 1'b1;
            rd_data   <= '0;
            bus.m_req <= 1'b0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          bus.m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_master.sv
// Self-checking bench for mem_access_master: directed scenarios plus random
// accesses, checked against a transaction-level model of the access rules.
module tb_mem_access_master;

  localparam int MEM_ADDR_W = 18;
  localparam int BASE_ADDR  = 1024;
  localparam int DEPTH      = 65280;
  localparam int TIMEOUT    = 15;
  localparam longint LIMIT  = longint'(BASE_ADDR) + 4 * longint'(DEPTH);

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] st_val;
  logic        freeze;
  logic [31:0] rd_data;
  logic        err;

  mem_access_master_if #(.MEM_ADDR_W(MEM_ADDR_W)) bus ();

  mem_access_master #(
    .MEM_ADDR_W(MEM_ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en),
    .address (address),
    .st_val  (st_val),
    .freeze  (freeze),
    .rd_data (rd_data),
    .err     (err),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Memory behind the port (responder side) and the model's view of memory
  logic [31:0] smem    [int unsigned];
  logic [31:0] ref_mem [longint];
  logic [31:0] exp_rd;
  int          ack_wait  = 0;
  int          req_cycle = 0;

  // Responder: acks after ack_wait extra cycles; random acks outside REQ must be ignored
  always @(negedge clk) begin
    if (bus.m_req) begin
      bus.m_ack   = (req_cycle == ack_wait);
      bus.m_rdata = smem.exists(int'(bus.m_addr)) ? smem[int'(bus.m_addr)] : 32'h0;
      req_cycle++;
    end else begin
      req_cycle   = 0;
      bus.m_ack   = 1'($urandom_range(0, 1));
      bus.m_rdata = $urandom;
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.m_req && bus.m_ack && bus.m_we) begin
      smem[int'(bus.m_addr)] = bus.m_wdata;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One pipeline access, started at a negedge in IDLE, ends at the negedge of the next IDLE
  task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input int wt, input bit keep, input string tag);
    bit     fault, tmo, stable;
    bit     exp_e;
    int     exp_req, frz, reqc;
    longint aa;
    aa     = longint'({32'h0, a});
    fault  = (r && w) || (a[1:0] != 2'b00) || (aa < BASE_ADDR) || (aa >= LIMIT);
    tmo    = !fault && (wt >= TIMEOUT);
    exp_req = fault ? 0 : (tmo ? TIMEOUT : wt + 1);
    exp_e  = fault || tmo;
    if (fault || tmo) exp_rd = 32'h0;
    else if (r)       exp_rd = ref_mem.exists(aa) ? ref_mem[aa] : 32'h0;
    else              ref_mem[aa] = d;

    mem_r_en = r; mem_w_en = w; address = a; st_val = d; ack_wait = wt;
    frz = 0; reqc = 0; stable = 1'b1;
    #1;
    while (freeze && frz < 100) begin
      frz++;
      if (bus.m_req) begin
        reqc++;
        if (bus.m_addr !== a[MEM_ADDR_W-1:0] || bus.m_wdata !== d || bus.m_we !== w) stable = 1'b0;
        address = $urandom;
        st_val  = $urandom;
      end
      @(negedge clk); #1;
    end
    chk({tag, "_freeze_cycles"}, frz, 1 + exp_req);
    chk({tag, "_req_cycles"}, reqc, exp_req);
    if (reqc > 0) chk({tag, "_req_stable"}, stable, 1);
    chk({tag, "_rd_data"}, rd_data, exp_rd);
    chk({tag, "_err"}, err, exp_e);
    chk({tag, "_done_req"}, bus.m_req, 0);
    $display("txn %-10s r=%0d w=%0d addr=%h wdata=%h wait=%0d freeze=%0d req=%0d rd=%h err=%0d",
             tag, r, w, a, d, wt, frz, reqc, rd_data, err);
    if (!keep) begin
      mem_r_en = 1'b0; mem_w_en = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ra, rdv;
    int          sel, wt;
    bit          rr, ww;

    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; address = '0; st_val = '0;
    for (int i = 0; i < 32; i++) begin
      rdv = $urandom;
      smem[BASE_ADDR + 4 * i]             = rdv;
      ref_mem[longint'(BASE_ADDR + 4 * i)] = rdv;
    end
    smem[32'h400] = 32'hDEADBEEF; ref_mem[64'h400] = 32'hDEADBEEF;
    smem[32'h404] = 32'h0;        ref_mem[64'h404] = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_req", bus.m_req, 0);
    chk("rst_m_we", bus.m_we, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_wdata", bus.m_wdata, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_err", err, 0);
    chk("rst_freeze", freeze, 0);
    $display("txn reset      m_req=%0d rd=%h err=%0d freeze=%0d", bus.m_req, rd_data, err, freeze);
    rst = 1'b0; exp_rd = 32'h0;
    @(negedge clk);

    access(1, 0, 32'h400, 32'h0, 0, 0, "load0");
    access(0, 1, 32'h404, 32'h12345678, 3, 0, "store3");
    access(1, 0, 32'h404, 32'h0, 0, 0, "load404");
    access(1, 0, 32'h402, 32'h0, 0, 0, "f_misal");
    access(1, 0, 32'h3FC, 32'h0, 0, 0, "f_low");
    access(1, 0, 32'h40000, 32'h0, 0, 0, "f_high");
    access(0, 1, 32'h40400, 32'hAAAA5555, 0, 0, "f_alias");
    access(1, 1, 32'h408, 32'h0, 0, 0, "f_both");
    access(1, 0, 32'h400, 32'h0, 40, 0, "tmo");
    access(1, 0, 32'h400, 32'h0, TIMEOUT - 1, 0, "ack_last");
    access(1, 0, 32'h400, 32'h0, 0, 1, "b2b_a");
    access(1, 0, 32'h408, 32'h0, 0, 0, "b2b_b");

    // Reset in the middle of a store whose ack never arrives
    mem_w_en = 1'b1; address = 32'h404; st_val = 32'hCAFEF00D; ack_wait = 1000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_w_en = 1'b0; exp_rd = 32'h0;
    #1;
    chk("rstreq_m_req", bus.m_req, 0);
    chk("rstreq_rd_data", rd_data, 0);
    chk("rstreq_err", err, 0);
    chk("rstreq_freeze_idle", freeze, 0);
    mem_r_en = 1'b1;
    #1;
    chk("rstreq_freeze_en", freeze, 1);
    mem_r_en = 1'b0;
    $display("txn rst_in_req m_req=%0d rd=%h err=%0d", bus.m_req, rd_data, err);
    @(negedge clk);
    access(1, 0, 32'h404, 32'h0, 0, 0, "after_rst");

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      ra = BASE_ADDR + 4 * $urandom_range(0, 31);
      else if (sel == 7) ra = (BASE_ADDR + 4 * $urandom_range(0, 31)) | 32'($urandom_range(1, 3));
      else if (sel == 8) ra = 32'($urandom_range(0, BASE_ADDR - 1));
      else               ra = 32'h0004_0000 | ($urandom & 32'hFFFF_FFFC);
      sel = $urandom_range(0, 9);
      wt  = (sel < 7) ? $urandom_range(0, 3) : ((sel == 7) ? TIMEOUT - 1 : ((sel == 8) ? TIMEOUT : TIMEOUT + 3));
      rr  = 1'($urandom_range(0, 1));
      ww  = !rr;
      if ($urandom_range(0, 9) == 0) begin rr = 1'b1; ww = 1'b1; end
      access(rr, ww, ra, $urandom, wt, 1'($urandom_range(0, 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
